// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame/baud defaults.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS            = 8;
    localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 234;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer with a configurable reset value.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready byte output and frame/overrun reporting.
// Define UART_RX_PARITY_EN for 8E1 frames and a parity_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    logic rxs;

    uart_state_e state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [7:0]       shreg, shreg_n;
    logic [7:0]       data_n;
    logic             valid_n, frame_err_n, overrun_n, busy_n;
`ifdef UART_RX_PARITY_EN
    logic             par_bit, par_bit_n;
    logic             parity_err_n;
`endif

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= frame_err_n;
            overrun   <= overrun_n;
            busy      <= busy_n;
`ifdef UART_RX_PARITY_EN
            par_bit    <= par_bit_n;
            parity_err <= parity_err_n;
`endif
        end
    end

    // Next-state and output logic; a new byte always wins over a pending one
    always_comb begin
        state_n     = state;
        cnt_n       = CNT_W'(cnt + CNT_W'(1));
        idx_n       = idx;
        shreg_n     = shreg;
        data_n      = data;
        valid_n     = valid & ~ready;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_n    = par_bit;
        parity_err_n = 1'b0;
`endif

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxs) state_n = START;
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_FULL) begin
                    cnt_n          = '0;
                    shreg_n[idx]   = rxs;
                    idx_n          = IDX_W'(idx + IDX_W'(1));
                    if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == CNT_FULL) begin
                    cnt_n     = '0;
                    par_bit_n = rxs;
                    state_n   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_n = '0;
                    if (rxs) begin
                        data_n    = shreg;
                        valid_n   = 1'b1;
                        overrun_n = valid & ~ready;
`ifdef UART_RX_PARITY_EN
                        parity_err_n = ^{shreg, par_bit};
`endif
                        state_n   = IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_n = '0;
                if (rxs) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit; scoreboard on received bytes.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] expq[$];
    int n_deliv = 0, n_ferr = 0, n_ovr = 0, n_vcyc = 0, n_perr = 0;
    logic valid_q = 1'b0;

    // Output monitor: detects each newly loaded byte and checks it against the scoreboard
    always @(posedge clk) begin
        logic [7:0] e;
        logic       deliv;
        #1;
        if (rst) begin
            valid_q = 1'b0;
        end else begin
            deliv = valid && (!valid_q || ready || overrun);
            if (valid)     n_vcyc++;
            if (frame_err) n_ferr++;
            if (overrun)   n_ovr++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) n_perr++;
            if (parity_err && !deliv) begin
                total++; bad++;
                $display("FAIL parity_align parity_err=1 without a new byte");
            end
`endif
            if (deliv) begin
                n_deliv++;
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL byte_unexpected got=%02h want=none", data);
                end else begin
                    e = expq.pop_front();
                    if (data !== e) begin
                        bad++;
                        $display("FAIL byte_data got=%02h want=%02h", data, e);
                    end
                end
            end
            valid_q = valid;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_deliv = 0; n_ferr = 0; n_ovr = 0; n_vcyc = 0; n_perr = 0;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^b) ^ par_flip);
`else
        if (par_flip) begin end
`endif
        send_bit(stop_v);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop_v;
        int         exp_deliv;
        int         exp_ferr;
        int         exp_vcyc;
    } vec_t;

    vec_t vecs[5];
    string hello;
    logic [7:0] c;

    initial begin
        vecs[0] = '{8'h48, 1'b1, 1, 0, 1};
        vecs[1] = '{8'h00, 1'b1, 1, 0, 1};
        vecs[2] = '{8'hFF, 1'b1, 1, 0, 1};
        vecs[3] = '{8'h3C, 1'b0, 0, 1, 0};
        vecs[4] = '{8'h81, 1'b1, 1, 0, 1};

        rst = 1'b1; rx = 1'b1; ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(valid), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single-frame vectors with ready high
        for (int v = 0; v < 5; v++) begin
            clear_counts();
            if (vecs[v].exp_deliv != 0) expq.push_back(vecs[v].b);
            send_frame(vecs[v].b, vecs[v].stop_v, 1'b0);
            repeat (24) @(negedge clk);
            check($sformatf("vec%0d_bytes", v), 32'(n_deliv), 32'(vecs[v].exp_deliv));
            check($sformatf("vec%0d_frame_err", v), 32'(n_ferr), 32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d_valid_cycles", v), 32'(n_vcyc), 32'(vecs[v].exp_vcyc));
            check($sformatf("vec%0d_overrun", v), 32'(n_ovr), 0);
            check($sformatf("vec%0d_perr", v), 32'(n_perr), 0);
            check($sformatf("vec%0d_busy", v), 32'(busy), 0);
            check($sformatf("vec%0d_queue", v), 32'(expq.size()), 0);
        end

        // Back-to-back string with no idle gap
        clear_counts();
        hello = "Hello, World!\n";
        for (int i = 0; i < hello.len(); i++) begin
            c = hello[i];
            expq.push_back(c);
        end
        for (int i = 0; i < hello.len(); i++) begin
            c = hello[i];
            send_frame(c, 1'b1, 1'b0);
        end
        repeat (24) @(negedge clk);
        check("hello_bytes", 32'(n_deliv), 14);
        check("hello_overrun", 32'(n_ovr), 0);
        check("hello_queue", 32'(expq.size()), 0);

        // Overrun with consumer stalled
        clear_counts();
        ready = 1'b0;
        expq.push_back(8'h55);
        expq.push_back(8'hAA);
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b1, 1'b0);
        repeat (24) @(negedge clk);
        check("ovr_valid", 32'(valid), 1);
        check("ovr_count", 32'(n_ovr), 1);
        check("ovr_data", 32'(data), 32'hAA);
        check("ovr_bytes", 32'(n_deliv), 2);
        ready = 1'b1;
        @(negedge clk);
        check("ovr_accept", 32'(valid), 0);

        // Frame error followed by a held-low line
        clear_counts();
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        check("brk_busy", 32'(busy), 1);
        check("brk_frame_err", 32'(n_ferr), 1);
        check("brk_bytes", 32'(n_deliv), 0);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("brk_release", 32'(busy), 0);

        // False start
        clear_counts();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        check("fs_busy", 32'(busy), 1);
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("fs_idle", 32'(busy), 0);
        check("fs_bytes", 32'(n_deliv), 0);
        check("fs_frame_err", 32'(n_ferr), 0);

        // Reset during bit 4, then a clean frame
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(c[i] ^ c[i] ^ ((8'hA5 >> i) & 8'h01) != 0);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1; rx = 1'b1;
        @(negedge clk);
        check("mid_rst_data", 32'(data), 0);
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_frame_err", 32'(frame_err), 0);
        check("mid_rst_overrun", 32'(overrun), 0);
        check("mid_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        clear_counts();
        expq.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (24) @(negedge clk);
        check("post_rst_bytes", 32'(n_deliv), 1);
        check("post_rst_frame_err", 32'(n_ferr), 0);
        check("post_rst_queue", 32'(expq.size()), 0);

`ifdef UART_RX_PARITY_EN
        clear_counts();
        expq.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b1);
        repeat (24) @(negedge clk);
        check("par_bytes", 32'(n_deliv), 1);
        check("par_err", 32'(n_perr), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
